ctrl_undd_param: RTL and testbench

//  Parametrised multicycle control FSM for the accumulator/stack processor. Decodes opcode per instruction
//  and drives all PC/RI/bank/memory/ALU/stack/IO enables and mux selects. Adds multi-channel IN/OUT,
//  a call-stack depth tracker with overflow/underflow fault, IN timeout, and halt resume.

---
 rtl/ctrl_undd_param_pkg.sv | 81 ++++++++
 rtl/ctrl_undd_param_if.sv | 42 ++++
 rtl/ctrl_undd_param_stk_guard.sv | 34 +++
 rtl/ctrl_undd_param.sv | 198 +++++++++++++++++++
 tb/tb_ctrl_undd_param.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_undd_param_pkg.sv
// Shared types for the multicycle controller: state encodings, fault codes
// and the opcode map, plus the opcode-to-class decoder.
package ctrl_undd_param_pkg;

  typedef enum logic [4:0] {
    FETCH     = 5'd0,
    DECODE    = 5'd1,
    ADDR      = 5'd2,
    MEM_RD    = 5'd3,
    MEM_WR    = 5'd4,
    WB_MEM    = 5'd5,
    R_EX      = 5'd6,
    I_EX      = 5'd7,
    WB        = 5'd8,
    BR_CALC   = 5'd9,
    BR_UPD    = 5'd10,
    JMP       = 5'd11,
    HALT      = 5'd12,
    LSTK_A    = 5'd13,
    LSTK_PUSH = 5'd14,
    SSTK_A    = 5'd15,
    SSTK_WR   = 5'd16,
    IN_WAIT   = 5'd17,
    IN_REL    = 5'd18,
    FAULT     = 5'd19
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_TMO  = 2'b11
  } fault_t;

  localparam logic [31:0] OP_R    = 32'd0;
  localparam logic [31:0] OP_ADDI = 32'd1;
  localparam logic [31:0] OP_SUBI = 32'd2;
  localparam logic [31:0] OP_ANDI = 32'd3;
  localparam logic [31:0] OP_ORI  = 32'd4;
  localparam logic [31:0] OP_LDI  = 32'd5;
  localparam logic [31:0] OP_LDR  = 32'd6;
  localparam logic [31:0] OP_STI  = 32'd7;
  localparam logic [31:0] OP_STR  = 32'd8;
  localparam logic [31:0] OP_BEQ  = 32'd9;
  localparam logic [31:0] OP_BNE  = 32'd10;
  localparam logic [31:0] OP_JMP  = 32'd11;
  localparam logic [31:0] OP_JAL  = 32'd12;
  localparam logic [31:0] OP_JST  = 32'd13;
  localparam logic [31:0] OP_HLT  = 32'd14;
  localparam logic [31:0] OP_LSTK = 32'd15;
  localparam logic [31:0] OP_SSTK = 32'd16;
  localparam logic [31:0] OP_IN   = 32'd17;
  localparam logic [31:0] OP_OUT  = 32'd18;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LDI, CLS_LDR, CLS_STI, CLS_STR, CLS_BR, CLS_JMP,
    CLS_JAL, CLS_JST, CLS_HLT, CLS_LSTK, CLS_SSTK, CLS_IN, CLS_OUT, CLS_NOP
  } op_cls_t;

  function automatic op_cls_t op_classify(input logic [31:0] op);
    case (op)
      OP_R:                             return CLS_R;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: return CLS_I;
      OP_LDI:                           return CLS_LDI;
      OP_LDR:                           return CLS_LDR;
      OP_STI:                           return CLS_STI;
      OP_STR:                           return CLS_STR;
      OP_BEQ, OP_BNE:                   return CLS_BR;
      OP_JMP:                           return CLS_JMP;
      OP_JAL:                           return CLS_JAL;
      OP_JST:                           return CLS_JST;
      OP_HLT:                           return CLS_HLT;
      OP_LSTK:                          return CLS_LSTK;
      OP_SSTK:                          return CLS_SSTK;
      OP_IN:                            return CLS_IN;
      OP_OUT:                           return CLS_OUT;
      default:                          return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_undd_param_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// enables/selects/status out.
interface ctrl_undd_param_if #(
  parameter int unsigned OPW       = 6,
  parameter int unsigned NCH       = 2,
  parameter int unsigned CHW       = 1,
  parameter int unsigned STK_DEPTH = 16
);
  localparam int unsigned DW = $clog2(STK_DEPTH + 1);

  logic [OPW-1:0] opcode;
  logic [CHW-1:0] canal;
  logic           zero;
  logic [NCH-1:0] enter;
  logic           resume;

  logic [4:0]     estado;
  logic           EscrevePC, EscreveRI, EscreveReg, EscreveMem;
  logic           pop, push;
  logic [NCH-1:0] controleIN, controleOUT;
  logic           SelMuxEndMem, SelMuxDadoMem, SelMuxPilha, SelMuxReg1;
  logic           SelMuxReg2, SelMuxUlaA, SelMuxIn;
  logic [1:0]     SelMuxUlaB, SelMuxPC, OpULA;
  logic [DW-1:0]  stk_depth;
  logic [1:0]     fault;

  modport master (
    input  opcode, canal, zero, enter, resume,
    output estado, EscrevePC, EscreveRI, EscreveReg, EscreveMem, pop, push,
           controleIN, controleOUT, SelMuxEndMem, SelMuxDadoMem, SelMuxPilha,
           SelMuxReg1, SelMuxReg2, SelMuxUlaA, SelMuxIn, SelMuxUlaB, SelMuxPC,
           OpULA, stk_depth, fault
  );

  modport slave (
    output opcode, canal, zero, enter, resume,
    input  estado, EscrevePC, EscreveRI, EscreveReg, EscreveMem, pop, push,
           controleIN, controleOUT, SelMuxEndMem, SelMuxDadoMem, SelMuxPilha,
           SelMuxReg1, SelMuxReg2, SelMuxUlaA, SelMuxIn, SelMuxUlaB, SelMuxPC,
           OpULA, stk_depth, fault
  );
endinterface

// File: rtl/ctrl_undd_param_stk_guard.sv
// Call/data stack occupancy tracker; grants push/pop only when legal and
// flags the illegal request as overflow/underflow.
module stk_guard #(
  parameter int unsigned STK_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push_req,
  input  logic                             i_pop_req,
  output logic                             o_push_ok,
  output logic                             o_pop_ok,
  output logic                             o_ovf,
  output logic                             o_unf,
  output logic [$clog2(STK_DEPTH+1)-1:0]   o_depth
);
  localparam int unsigned DW = $clog2(STK_DEPTH + 1);

  logic [DW-1:0] r_depth;
  logic          w_full, w_empty;

  assign w_full    = (r_depth == DW'(STK_DEPTH));
  assign w_empty   = (r_depth == '0);
  assign o_push_ok = i_push_req & ~w_full;
  assign o_pop_ok  = i_pop_req & ~w_empty;
  assign o_ovf     = i_push_req & w_full;
  assign o_unf     = i_pop_req & w_empty;
  assign o_depth   = r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_depth <= '0;
    else if (o_push_ok) r_depth <= r_depth + DW'(1);
    else if (o_pop_ok)  r_depth <= r_depth - DW'(1);
  end
endmodule

// File: rtl/ctrl_undd_param.sv
// Multicycle control FSM for the accumulator/stack processor with
// multi-channel IN/OUT, stack guard, IN timeout and halt resume.
module ctrl_undd_param
  import ctrl_undd_param_pkg::*;
#(
  parameter int unsigned OPW       = 6,
  parameter int unsigned NCH       = 2,
  parameter int unsigned CHW       = 1,
  parameter int unsigned STK_DEPTH = 16,
  parameter int unsigned IN_TMO    = 0
) (
  input logic               clk,
  input logic               reset,
  ctrl_undd_param_if.master bus
);
  localparam int unsigned TW = (IN_TMO > 1) ? $clog2(IN_TMO) : 1;
  localparam int unsigned DW = $clog2(STK_DEPTH + 1);

  state_t         r_state;
  fault_t         r_fault;
  logic [TW-1:0]  r_tmo;

  logic [OPW-1:0] w_opcode;
  logic [CHW-1:0] w_canal;
  op_cls_t        w_cls;
  logic [NCH-1:0] w_chan_1h;
  logic           w_enter_sel;
  logic           w_push_req, w_pop_req, w_push_ok, w_pop_ok, w_ovf, w_unf;
  logic [DW-1:0]  w_depth;

  assign w_opcode    = bus.opcode;
  assign w_canal     = bus.canal;
  assign w_cls       = op_classify(32'(w_opcode));
  assign w_chan_1h   = NCH'(1) << w_canal;
  // Masked reduction rather than enter[canal]: a canal beyond NCH selects nothing.
  assign w_enter_sel = |(bus.enter & w_chan_1h);

  assign w_push_req = (r_state == LSTK_PUSH) || (r_state == JMP && w_cls == CLS_JAL);
  assign w_pop_req  = (r_state == SSTK_WR) || (r_state == BR_UPD && w_cls == CLS_JST);

  stk_guard #(.STK_DEPTH(STK_DEPTH)) u_stk_guard (
    .clk        (clk),
    .rst_n      (reset),
    .i_push_req (w_push_req),
    .i_pop_req  (w_pop_req),
    .o_push_ok  (w_push_ok),
    .o_pop_ok   (w_pop_ok),
    .o_ovf      (w_ovf),
    .o_unf      (w_unf),
    .o_depth    (w_depth)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_fault <= FLT_NONE;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        FETCH:   r_state <= DECODE;
        DECODE: begin
          case (w_cls)
            CLS_R:                             r_state <= R_EX;
            CLS_I:                             r_state <= I_EX;
            CLS_LDI, CLS_LDR, CLS_STI, CLS_STR: r_state <= ADDR;
            CLS_BR:                            r_state <= BR_CALC;
            CLS_JMP, CLS_JAL:                  r_state <= JMP;
            CLS_JST:                           r_state <= BR_UPD;
            CLS_HLT:                           r_state <= HALT;
            CLS_LSTK:                          r_state <= LSTK_A;
            CLS_SSTK:                          r_state <= SSTK_A;
            CLS_IN: begin
              r_state <= IN_WAIT;
              r_tmo   <= '0;
            end
            default:                           r_state <= FETCH;
          endcase
        end
        ADDR:      r_state <= (w_cls == CLS_LDI || w_cls == CLS_LDR) ? MEM_RD : MEM_WR;
        MEM_RD:    r_state <= WB_MEM;
        MEM_WR:    r_state <= FETCH;
        WB_MEM:    r_state <= FETCH;
        R_EX:      r_state <= WB;
        I_EX:      r_state <= WB;
        WB:        r_state <= FETCH;
        BR_CALC:   r_state <= BR_UPD;
        LSTK_A:    r_state <= LSTK_PUSH;
        SSTK_A:    r_state <= SSTK_WR;
        BR_UPD, SSTK_WR: begin
          if (w_unf) begin
            r_state <= FAULT;
            r_fault <= FLT_UNF;
          end else begin
            r_state <= FETCH;
          end
        end
        JMP, LSTK_PUSH: begin
          if (w_ovf) begin
            r_state <= FAULT;
            r_fault <= FLT_OVF;
          end else begin
            r_state <= FETCH;
          end
        end
        IN_WAIT: begin
          if (w_enter_sel) begin
            r_state <= IN_REL;
          end else if (IN_TMO != 0 && r_tmo == TW'(IN_TMO - 1)) begin
            r_state <= FAULT;
            r_fault <= FLT_TMO;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        IN_REL:    if (!w_enter_sel) r_state <= FETCH;
        HALT:      if (bus.resume) r_state <= FETCH;
        FAULT:     r_state <= FAULT;
        default:   r_state <= FETCH;
      endcase
    end
  end

  assign bus.estado    = r_state;
  assign bus.fault     = r_fault;
  assign bus.stk_depth = w_depth;
  assign bus.push      = w_push_ok;
  assign bus.pop       = w_pop_ok;

  always_comb begin
    bus.EscrevePC     = 1'b0;
    bus.EscreveRI     = 1'b0;
    bus.EscreveReg    = 1'b0;
    bus.EscreveMem    = 1'b0;
    bus.controleIN    = '0;
    bus.controleOUT   = '0;
    bus.SelMuxEndMem  = 1'b0;
    bus.SelMuxDadoMem = 1'b0;
    bus.SelMuxPilha   = 1'b0;
    bus.SelMuxReg1    = 1'b0;
    bus.SelMuxReg2    = 1'b0;
    bus.SelMuxUlaA    = 1'b0;
    bus.SelMuxIn      = 1'b0;
    bus.SelMuxUlaB    = 2'b00;
    bus.SelMuxPC      = 2'b00;
    bus.OpULA         = 2'b00;
    case (r_state)
      FETCH: begin
        bus.EscreveRI  = 1'b1;
        bus.OpULA      = 2'b01;
        bus.SelMuxUlaB = 2'b01;
        bus.SelMuxIn   = 1'b1;
      end
      DECODE: begin
        bus.EscrevePC  = (w_cls != CLS_HLT);
        bus.SelMuxUlaB = 2'b01;
        if (w_cls == CLS_OUT) bus.controleOUT = w_chan_1h;
      end
      ADDR: begin
        bus.SelMuxEndMem = 1'b1;
        bus.SelMuxUlaA   = 1'b1;
        bus.SelMuxUlaB   = 2'b11;
        bus.OpULA        = (w_cls == CLS_STI || w_cls == CLS_LDI) ? 2'b11 : 2'b01;
      end
      MEM_WR:  bus.EscreveMem = 1'b1;
      WB_MEM: begin
        bus.EscreveReg = 1'b1;
        bus.SelMuxReg2 = 1'b1;
      end
      WB:      bus.EscreveReg = 1'b1;
      BR_CALC: bus.SelMuxPC = 2'b01;
      BR_UPD: begin
        if (w_cls == CLS_JST) begin
          bus.EscrevePC = 1'b1;
          bus.SelMuxPC  = 2'b11;
        end else begin
          bus.EscrevePC = bus.zero;
          bus.SelMuxPC  = 2'b10;
        end
      end
      JMP: begin
        bus.EscrevePC  = 1'b1;
        bus.SelMuxUlaB = 2'b11;
      end
      SSTK_WR: begin
        bus.EscreveMem    = 1'b1;
        bus.SelMuxDadoMem = 1'b1;
      end
      IN_WAIT: begin
        if (w_enter_sel) begin
          bus.controleIN = w_chan_1h;
          bus.EscreveReg = 1'b1;
          bus.SelMuxIn   = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl_undd_param.sv
// Directed bench for ctrl_undd_param (STK_DEPTH=16, IN_TMO=8) with
// hand-computed expectations.
module tb_ctrl_undd_param;
  localparam logic [5:0] OP_ADDI = 6'd1, OP_LDI = 6'd5, OP_STR = 6'd8, OP_BEQ = 6'd9;
  localparam logic [5:0] OP_JAL = 6'd12, OP_JST = 6'd13, OP_HLT = 6'd14;
  localparam logic [5:0] OP_LSTK = 6'd15, OP_SSTK = 6'd16, OP_IN = 6'd17, OP_OUT = 6'd18;
  localparam logic [5:0] OP_UNDEF = 6'd63;

  localparam int S_FETCH = 0, S_DECODE = 1, S_ADDR = 2, S_MEM_RD = 3, S_MEM_WR = 4;
  localparam int S_WB_MEM = 5, S_I_EX = 7, S_WB = 8, S_BR_CALC = 9, S_BR_UPD = 10;
  localparam int S_JMP = 11, S_HALT = 12, S_LSTK_A = 13, S_LSTK_PUSH = 14;
  localparam int S_SSTK_A = 15, S_SSTK_WR = 16, S_IN_WAIT = 17, S_IN_REL = 18, S_FAULT = 19;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  ctrl_undd_param_if #(.OPW(6), .NCH(2), .CHW(1), .STK_DEPTH(16)) bus ();

  ctrl_undd_param #(
    .OPW(6), .NCH(2), .CHW(1), .STK_DEPTH(16), .IN_TMO(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int bad;
    reset = 1'b0;
    bus.opcode = '0; bus.canal = '0; bus.zero = 1'b0; bus.enter = '0; bus.resume = 1'b0;
    step(); step();
    check_eq("rst_estado", bus.estado, S_FETCH);
    check_eq("rst_ri", bus.EscreveRI, 1);
    check_eq("rst_opula", bus.OpULA, 2'b01);
    check_eq("rst_ulab", bus.SelMuxUlaB, 2'b01);
    check_eq("rst_selin", bus.SelMuxIn, 1);
    check_eq("rst_pc", bus.EscrevePC, 0);
    check_eq("rst_fault", bus.fault, 0);
    check_eq("rst_depth", bus.stk_depth, 0);
    reset = 1'b1;
    #1;

    // addi: FETCH, DECODE, I_EX, WB, FETCH
    bus.opcode = OP_ADDI; #1;
    check_eq("addi_c1_reg", bus.EscreveReg, 0);
    step(); check_eq("addi_c2_st", bus.estado, S_DECODE);
    check_eq("addi_c2_pc", bus.EscrevePC, 1);
    check_eq("addi_c2_reg", bus.EscreveReg, 0);
    step(); check_eq("addi_c3_st", bus.estado, S_I_EX);
    check_eq("addi_c3_reg", bus.EscreveReg, 0);
    step(); check_eq("addi_c4_st", bus.estado, S_WB);
    check_eq("addi_c4_reg", bus.EscreveReg, 1);
    step(); check_eq("addi_c5_st", bus.estado, S_FETCH);

    // ldi: immediate address uses OpULA=11
    bus.opcode = OP_LDI;
    step(); step();
    check_eq("ldi_addr_st", bus.estado, S_ADDR);
    check_eq("ldi_opula", bus.OpULA, 2'b11);
    check_eq("ldi_endmem", bus.SelMuxEndMem, 1);
    step(); check_eq("ldi_memrd", bus.estado, S_MEM_RD);
    step(); check_eq("ldi_wbmem_reg", bus.EscreveReg, 1);
    check_eq("ldi_wbmem_reg2", bus.SelMuxReg2, 1);
    step(); check_eq("ldi_done", bus.estado, S_FETCH);

    // str, reset asserted mid-MEM_WR
    bus.opcode = OP_STR;
    step(); step();
    check_eq("str_opula", bus.OpULA, 2'b01);
    step(); check_eq("str_memwr_st", bus.estado, S_MEM_WR);
    check_eq("str_memwr_we", bus.EscreveMem, 1);
    reset = 1'b0; #1;
    check_eq("str_rst_we", bus.EscreveMem, 0);
    check_eq("str_rst_st", bus.estado, S_FETCH);
    step(); reset = 1'b1; #1;
    step(); check_eq("str_after_rel", bus.estado, S_DECODE);
    do_reset();

    // beq zero=1 then zero=0
    bus.opcode = OP_BEQ; bus.zero = 1'b1;
    step(); step();
    check_eq("beq1_calc_st", bus.estado, S_BR_CALC);
    check_eq("beq1_calc_pc", bus.SelMuxPC, 2'b01);
    step(); check_eq("beq1_upd_st", bus.estado, S_BR_UPD);
    check_eq("beq1_upd_we", bus.EscrevePC, 1);
    check_eq("beq1_upd_sel", bus.SelMuxPC, 2'b10);
    step(); bus.zero = 1'b0;
    step(); step(); step();
    check_eq("beq0_upd_st", bus.estado, S_BR_UPD);
    check_eq("beq0_upd_we", bus.EscrevePC, 0);
    check_eq("beq0_upd_sel", bus.SelMuxPC, 2'b10);
    step();

    // jst at depth 0 -> underflow
    bus.opcode = OP_JST;
    step(); step();
    check_eq("jst_upd_st", bus.estado, S_BR_UPD);
    check_eq("jst_pop", bus.pop, 0);
    check_eq("jst_sel", bus.SelMuxPC, 2'b11);
    step(); check_eq("jst_fault_st", bus.estado, S_FAULT);
    check_eq("jst_fault", bus.fault, 2'b10);
    do_reset();
    check_eq("jst_clr_fault", bus.fault, 0);

    // lstk then sstk: depth 0 -> 1 -> 0
    bus.opcode = OP_LSTK;
    step(); step(); check_eq("lstk_a", bus.estado, S_LSTK_A);
    step(); check_eq("lstk_push_st", bus.estado, S_LSTK_PUSH);
    check_eq("lstk_push", bus.push, 1);
    step(); check_eq("lstk_depth", bus.stk_depth, 1);
    bus.opcode = OP_SSTK;
    step(); step(); check_eq("sstk_a", bus.estado, S_SSTK_A);
    step(); check_eq("sstk_wr_st", bus.estado, S_SSTK_WR);
    check_eq("sstk_pop", bus.pop, 1);
    check_eq("sstk_mem", bus.EscreveMem, 1);
    check_eq("sstk_dado", bus.SelMuxDadoMem, 1);
    step(); check_eq("sstk_depth", bus.stk_depth, 0);

    // 16 jal fill the stack, the 17th overflows
    bus.opcode = OP_JAL;
    for (int i = 0; i < 16; i++) begin
      step(); step();
      check_eq($sformatf("jal%0d_push", i), bus.push, 1);
      step();
    end
    check_eq("jal_depth16", bus.stk_depth, 16);
    step(); step();
    check_eq("jal17_st", bus.estado, S_JMP);
    check_eq("jal17_push", bus.push, 0);
    step(); check_eq("jal17_fault_st", bus.estado, S_FAULT);
    check_eq("jal17_fault", bus.fault, 2'b01);
    check_eq("jal17_depth", bus.stk_depth, 16);
    step(); step(); step();
    check_eq("fault_sticky_st", bus.estado, S_FAULT);
    do_reset();
    check_eq("depth_after_rst", bus.stk_depth, 0);

    // in canal=1: wrong-channel enter ignored, right one captured
    bus.opcode = OP_IN; bus.canal = 1'b1; bus.enter = 2'b01;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("in_wait%0d_st", k), bus.estado, S_IN_WAIT);
      check_eq($sformatf("in_wait%0d_cin", k), bus.controleIN, 0);
      step();
    end
    bus.enter = 2'b10; #1;
    check_eq("in_cap_cin", bus.controleIN, 2'b10);
    check_eq("in_cap_reg", bus.EscreveReg, 1);
    check_eq("in_cap_selin", bus.SelMuxIn, 1);
    step(); check_eq("in_rel_st", bus.estado, S_IN_REL);
    check_eq("in_rel_cin", bus.controleIN, 0);
    step(); check_eq("in_rel_hold", bus.estado, S_IN_REL);
    bus.enter = 2'b00;
    step(); check_eq("in_done", bus.estado, S_FETCH);

    // IN timeout after 8 waiting cycles
    step(); step();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.estado != 5'(S_IN_WAIT)) bad++;
      step();
    end
    check_eq("tmo_wait_cycles", bad, 0);
    check_eq("tmo_st", bus.estado, S_FAULT);
    check_eq("tmo_fault", bus.fault, 2'b11);
    do_reset();

    // out canal=0
    bus.opcode = OP_OUT; bus.canal = 1'b0;
    step(); check_eq("out_cout", bus.controleOUT, 2'b01);
    step(); check_eq("out_done", bus.estado, S_FETCH);

    // undefined opcode is a NOP
    bus.opcode = OP_UNDEF;
    step(); step(); check_eq("undef_fetch", bus.estado, S_FETCH);

    // hlt holds 100 cycles, resume returns to FETCH
    bus.opcode = OP_HLT;
    step(); check_eq("hlt_pc", bus.EscrevePC, 0);
    step();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.estado != 5'(S_HALT)) bad++;
      step();
    end
    check_eq("hlt_hold", bad, 0);
    bus.resume = 1'b1;
    step(); check_eq("hlt_resume", bus.estado, S_FETCH);
    bus.resume = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
